mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter AW, default 8: word-address width; memory holds 2**AW 32-bit words.
REQ-002 Parameter WAIT, default 2: wait cycles, legal range 0..15.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  core presents a request.
REQ-007 req_ready  output  1  responder accepts a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_wstrb  input  4  store byte enables; bit i enables bits 8i+7..8i.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  core takes the response.
REQ-014 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 resp_err  output  1  request was misaligned or out of range.

Function
REQ-016 FSM states SHALL be IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE, and SHALL be combinational from state only.
REQ-018 Accept = req_valid && req_ready at a rising edge; all req_* fields latched at that edge.
REQ-019 On accept: WAIT=0 -> RESP; else -> WAIT, counter loaded with WAIT.
REQ-020 WAIT: counter decrements each cycle; at counter==1 -> RESP.
REQ-021 resp_valid SHALL rise exactly WAIT+1 cycles after the accepting edge.
REQ-022 Memory access SHALL occur on the edge entering RESP: load data captured into resp_rdata; store writes only strobed bytes.
REQ-023 Error = latched addr[1:0]!=0 or addr[31:AW+2]!=0; on error: no memory write, resp_rdata=0, resp_err=1.
REQ-024 Store with req_wstrb=0 SHALL complete normally without changing memory.
REQ-025 In RESP, resp_valid=1 and resp_rdata/resp_err SHALL hold stable until resp_ready=1.
REQ-026 RESP with resp_ready=1 -> IDLE next cycle; resp_valid falls, req_ready rises.
REQ-027 Responder SHALL accept no new request until the previous response handshakes; max throughput one request per WAIT+2 cycles.
REQ-028 req_valid while not in IDLE SHALL be ignored (held by core per handshake).
REQ-029 A load after a store to the same word SHALL return the updated data.
REQ-030 resp_valid, resp_rdata, resp_err SHALL be registered outputs.

Reset
REQ-031 resetn=0 SHALL immediately force: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0; req_ready 1 while resetn=1 after.
REQ-032 Reset in WAIT SHALL abandon the request; an uncommitted store SHALL NOT modify memory.
REQ-033 Memory contents are not reset; simulation initial contents are all zero.
REQ-034 First accept permitted on the first rising edge with resetn=1.

Verification
REQ-035 WAIT=2: store addr 0x10 data 0xDEADBEEF strb 0xF, then load 0x10 -> resp_rdata 0xDEADBEEF, resp_err 0, resp_valid 3 cycles after each accept.
REQ-036 Partial store: after REQ-035, store 0x10 data 0x000000AA strb 0x1 -> load returns 0xDEADBEAA.
REQ-037 Load addr 0x13 and load addr 0x400 (AW=8) -> resp_err 1, resp_rdata 0; store 0x401 leaves memory unchanged.
REQ-038 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata stable, req_ready 0, req_valid ignored; release -> IDLE next cycle.
REQ-039 Reset after store accept, during WAIT -> outputs cleared at once; later load of that address returns prior value.
REQ-040 WAIT=0: back-to-back requests with resp_ready tied 1 -> each response 1 cycle after accept, one accept per 2 cycles.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake,
// with a fixed, parameterised access latency.
module mem_responder #(
  parameter int AW   = 8,
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic [31:0] mem [2**AW];

  logic          accept;
  logic          hit;
  logic          a_we;
  logic [31:0]   a_addr;
  logic [31:0]   a_wdata;
  logic [3:0]    a_wstrb;
  logic          a_err;
  logic [AW-1:0] a_idx;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // With zero wait the access happens on the accepting edge itself,
  // so the live request fields are used instead of the latched copy.
  always_comb begin
    a_we    = we_q;
    a_addr  = addr_q;
    a_wdata = wdata_q;
    a_wstrb = wstrb_q;
    if (state == ST_IDLE) begin
      a_we    = req_we;
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_wstrb = req_wstrb;
    end
    hit = resetn &&
          ((state == ST_IDLE && accept && WAIT == 0) ||
           (state == ST_WAIT && cnt == 4'd1));
    a_err = (a_addr[1:0] != 2'b00) ||
            ((a_addr >> (AW + 2)) != 32'd0);
    a_idx = a_addr[AW+1:2];
  end

  always_ff @(posedge clk) begin
    if (hit && a_we && !a_err) begin
      for (int b = 0; b < 4; b++) begin
        if (a_wstrb[b]) mem[a_idx][8*b +: 8] <= a_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (WAIT == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_CNT;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (hit) begin
        resp_valid <= 1'b1;
        resp_err   <= a_err;
        resp_rdata <= (a_err || a_we) ? 32'd0 : mem[a_idx];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT=2 instance driven from a
// vector table plus corner sequences, and a WAIT=0 back-to-back instance.
module tb_mem_responder;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid0 = 0, req_ready0, req_we0 = 0;
  logic [31:0] req_addr0 = 0, req_wdata0 = 0;
  logic [3:0]  req_wstrb0 = 0;
  logic        resp_valid0, resp_ready0 = 0, resp_err0;
  logic [31:0] resp_rdata0;

  logic        req_valid1 = 0, req_ready1, req_we1 = 0;
  logic [31:0] req_addr1 = 0, req_wdata1 = 0;
  logic [3:0]  req_wstrb1 = 0;
  logic        resp_valid1, resp_ready1 = 1, resp_err1;
  logic [31:0] resp_rdata1;

  mem_responder #(.AW(8), .WAIT(2)) dut0 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we0), .req_addr(req_addr0),
    .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  mem_responder #(.AW(8), .WAIT(0)) dut1 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we1), .req_addr(req_addr1),
    .req_wdata(req_wdata1), .req_wstrb(req_wstrb1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  int tests = 0;
  int fails = 0;

  vec_t tab0 [16];
  vec_t tab1 [6];

  task automatic chk(input string nm, input int id,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s #%0d got %h want %h", nm, id, act, exp);
    end
  endtask

  task automatic drive0(input vec_t v);
    req_we0    = v.we;
    req_addr0  = v.addr;
    req_wdata0 = v.wdata;
    req_wstrb0 = v.wstrb;
  endtask

  task automatic drive1(input vec_t v);
    req_we1    = v.we;
    req_addr1  = v.addr;
    req_wdata1 = v.wdata;
    req_wstrb1 = v.wstrb;
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic do_req0(input vec_t v, input int id);
    int n;
    drive0(v);
    req_valid0  = 1'b1;
    resp_ready0 = 1'b1;
    chk("req_ready_idle", id, 32'(req_ready0), 32'd1);
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    n = 1;
    while (!resp_valid0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", id, n, 32'd3);
    chk("rdata", id, resp_rdata0, v.rdata);
    chk("err", id, 32'(resp_err0), 32'(v.err));
    @(posedge clk); #1;
    chk("valid_drop", id, 32'(resp_valid0), 32'd0);
    chk("ready_back", id, 32'(req_ready0), 32'd1);
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [31:0] r, input logic e);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.wstrb = s;
    v.rdata = r; v.err = e;
    return v;
  endfunction

  initial begin
    int n;
    vec_t v;

    tab0[0]  = mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    tab0[1]  = mk(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    tab0[2]  = mk(1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 0);
    tab0[3]  = mk(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 0);
    tab0[4]  = mk(0, 32'h13, 32'h0, 4'h0, 32'h0, 1);
    tab0[5]  = mk(0, 32'h400, 32'h0, 4'h0, 32'h0, 1);
    tab0[6]  = mk(1, 32'h401, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    tab0[7]  = mk(1, 32'h410, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    tab0[8]  = mk(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 0);
    tab0[9]  = mk(1, 32'h10, 32'h12345678, 4'h0, 32'h0, 0);
    tab0[10] = mk(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 0);
    tab0[11] = mk(1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0, 0);
    tab0[12] = mk(0, 32'h3FC, 32'h0, 4'h0, 32'hCAFEF00D, 0);
    tab0[13] = mk(1, 32'h14, 32'h55667788, 4'hF, 32'h0, 0);
    tab0[14] = mk(1, 32'h14, 32'h11223344, 4'hA, 32'h0, 0);
    tab0[15] = mk(0, 32'h14, 32'h0, 4'h0, 32'h11663388, 0);

    tab1[0] = mk(1, 32'h20, 32'h01020304, 4'hF, 32'h0, 0);
    tab1[1] = mk(0, 32'h20, 32'h0, 4'h0, 32'h01020304, 0);
    tab1[2] = mk(0, 32'h21, 32'h0, 4'h0, 32'h0, 1);
    tab1[3] = mk(1, 32'h20, 32'hAB000000, 4'h8, 32'h0, 0);
    tab1[4] = mk(0, 32'h20, 32'h0, 4'h0, 32'hAB020304, 0);
    tab1[5] = mk(1, 32'h800, 32'h1, 4'hF, 32'h0, 1);

    #1;
    chk("rst_valid", 0, 32'(resp_valid0), 32'd0);
    chk("rst_rdata", 0, resp_rdata0, 32'd0);
    chk("rst_err", 0, 32'(resp_err0), 32'd0);
    chk("rst_ready", 0, 32'(req_ready0), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;

    for (int i = 0; i < 16; i++) do_req0(tab0[i], i);

    // WAIT=0 back-to-back, responses always taken
    drive1(tab1[0]);
    req_valid1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("b2b_ready", i, 32'(req_ready1), 32'd1);
      @(posedge clk); #1;
      chk("b2b_valid", i, 32'(resp_valid1), 32'd1);
      chk("b2b_rdata", i, resp_rdata1, tab1[i].rdata);
      chk("b2b_err", i, 32'(resp_err1), 32'(tab1[i].err));
      chk("b2b_busy", i, 32'(req_ready1), 32'd0);
      if (i < 5) drive1(tab1[i+1]);
      else req_valid1 = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b_idle", 0, 32'(resp_valid1), 32'd0);

    // Backpressure with a competing request held on the bus
    drive0(mk(0, 32'h10, 32'h0, 4'h0, 32'h0, 0));
    req_valid0  = 1'b1;
    resp_ready0 = 1'b0;
    @(posedge clk); #1;
    drive0(mk(1, 32'h10, 32'h0, 4'hF, 32'h0, 0));
    n = 0;
    while (!resp_valid0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_latency", 0, n, 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", i, 32'(resp_valid0), 32'd1);
      chk("bp_rdata", i, resp_rdata0, 32'hDEADBEAA);
      chk("bp_err", i, 32'(resp_err0), 32'd0);
      chk("bp_ready", i, 32'(req_ready0), 32'd0);
      @(posedge clk); #1;
    end
    req_valid0  = 1'b0;
    resp_ready0 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 0, 32'(resp_valid0), 32'd0);
    chk("bp_release_ready", 0, 32'(req_ready0), 32'd1);
    do_req0(mk(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 0), 100);

    // Reset while a store waits: no commit, outputs cleared immediately
    drive0(mk(1, 32'h10, 32'h0BADF00D, 4'hF, 32'h0, 0));
    req_valid0 = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    chk("wait_busy", 0, 32'(req_ready0), 32'd0);
    resetn = 1'b0;
    #1;
    chk("arst_valid", 0, 32'(resp_valid0), 32'd0);
    chk("arst_rdata", 0, resp_rdata0, 32'd0);
    chk("arst_err", 0, 32'(resp_err0), 32'd0);
    chk("arst_ready", 0, 32'(req_ready0), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    chk("arst_hold", 0, 32'(resp_valid0), 32'd0);
    resetn = 1'b1;
    do_req0(mk(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 0), 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
